counter_step_scheduler: RTL and testbench
=========================================

# counter_step_scheduler

Sequencer and two-way arbiter for the shared 2-bit up/down counter. Two requesters each ask for a run of N counter steps in one direction. The block grants them round-robin and drives the counter's step and direction controls one step per cycle. It keeps a registered mirror of the counter value and pulses a per-requester done when that requester's run completes.

## Interface
Parameters:
- LEN_W, 4, width of the step-count field; a run is 0 to 2^LEN_W-1 steps.
- CNT_W, 2, width of the counter and of o_count.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req0_valid  input  1  requester 0 has a run pending; held until accepted.
- req0_up  input  1  requester 0 direction: 1 = up, 0 = down.
- req0_len  input  LEN_W  requester 0 step count.
- req1_valid, req1_up, req1_len  input  1 / 1 / LEN_W  same fields for requester 1.
- hold  input  1  pauses stepping while high; state and remaining count are frozen.
- o_ready0  output  1  combinational; accept strobe for requester 0.
- o_ready1  output  1  combinational; accept strobe for requester 1.
- o_step  output  1  combinational; counter step enable for this cycle.
- o_up  output  1  registered; direction of the current run.
- o_count  output  CNT_W  registered; mirror of the counter value.
- o_busy  output  1  combinational; high in RUN or DONE.
- o_done0  output  1  registered-state decode; 1-cycle pulse when requester 0's run finishes.
- o_done1  output  1  registered-state decode; 1-cycle pulse when requester 1's run finishes.

## Operation
- State machine has three states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE with no valid request: stays in IDLE, all strobes 0.
- IDLE with one valid request: that requester is granted.
- IDLE with both valid: the requester not served last is granted. The priority pointer starts at requester 0 after reset.
- On grant:
  - o_readyX = 1 for that cycle only.
  - dir, len and owner are latched; the pointer is updated.
  - Next state is RUN if len != 0, otherwise DONE.
- RUN, hold = 0:
  - o_step = 1; o_count becomes o_count ± 1 at the next edge.
  - Arithmetic is modulo 2^CNT_W: 3+1 = 0 and 0-1 = 3.
  - The remaining count decrements. When remaining == 1, next state is DONE.
- RUN, hold = 1: o_step = 0; count and remaining are unchanged.
- DONE: o_doneX = 1 for the latched owner for exactly one cycle, then IDLE. No request is accepted in DONE.
- Handshake rules:
  - A requester must keep valid and its fields stable until ready.
  - Fields are sampled only on the ready cycle.
  - Valid asserted or changed during RUN/DONE is ignored until IDLE.
- o_ready0 and o_ready1 are never high together. Neither is high outside IDLE.
- Reset at any time:
  - Returns to IDLE and aborts the current run; no done pulse is issued.
  - o_count = 0, o_up = 0, pointer = requester 0.
  - All strobes are 0 during the reset cycle.

## Timing
- Accept at cycle t; steps occur in cycles t+1 … t+len when hold stays low.
- The done pulse is at cycle t+len+1. The earliest next accept is t+len+2.
- For len = 0: done at t+1, next accept at t+2.
- Each hold cycle during RUN delays the steps and the done pulse by one cycle.
- o_count reflects a step one cycle after the o_step cycle.
- o_up is valid from t+1 through the DONE cycle.
- Reset values: o_ready0/1 = 0, o_step = 0, o_up = 0, o_count = 0, o_busy = 0, o_done0/1 = 0.

## Test plan
- Reset, then req0 up, len = 3, at cycle t:
  - o_ready0 at t; o_step high t+1 … t+3.
  - o_count 1, 2, 3 at t+2 … t+4; o_done0 at t+4.
- From o_count = 0, req1 down, len = 2:
  - o_count 3 then 2 (wrap-around); o_done1 pulses once; o_up = 0 throughout.
- Both valid in IDLE, twice in a row:
  - First grant goes to req0, second to req1; the ready strobes never overlap.
- req0 len = 0: o_ready0 at t, o_done0 at t+1, no o_step, o_count unchanged.
- hold high for 2 cycles mid-run, len = 4: four steps total; done is delayed by exactly 2 cycles.
- rst asserted during RUN after 2 of 5 steps: next cycle is IDLE, o_count = 0, no o_done pulse.

Source files
------------

// File: rtl/counter_step_scheduler_if.sv
// Request/step/done signal bundle between the two requesters and the
// counter step scheduler.
interface counter_step_scheduler_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 2
);
  logic             req0_valid;
  logic             req0_up;
  logic [LEN_W-1:0] req0_len;
  logic             req1_valid;
  logic             req1_up;
  logic [LEN_W-1:0] req1_len;
  logic             hold;
  logic             o_ready0;
  logic             o_ready1;
  logic             o_step;
  logic             o_up;
  logic [CNT_W-1:0] o_count;
  logic             o_busy;
  logic             o_done0;
  logic             o_done1;

  modport master (
    output req0_valid, req0_up, req0_len,
    output req1_valid, req1_up, req1_len,
    output hold,
    input  o_ready0, o_ready1, o_step, o_up, o_count, o_busy, o_done0, o_done1
  );

  modport slave (
    input  req0_valid, req0_up, req0_len,
    input  req1_valid, req1_up, req1_len,
    input  hold,
    output o_ready0, o_ready1, o_step, o_up, o_count, o_busy, o_done0, o_done1
  );
endinterface

// File: rtl/counter_step_scheduler.sv
// Round-robin arbiter and step sequencer for a shared up/down counter; one
// counter step per cycle, with a registered mirror of the counter value.
module counter_step_scheduler #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  counter_step_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             ptr_q;      // requester favoured on a tie
  logic             owner_q;
  logic             up_q;
  logic [LEN_W-1:0] rem_q;
  logic [CNT_W-1:0] count_q;

  logic             grant0, grant1, step;
  logic             grant_up;
  logic [LEN_W-1:0] grant_len;

  always_comb begin
    state_d   = state_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    step      = 1'b0;
    grant_up  = 1'b0;
    grant_len = '0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) grant0 = 1'b1;
        else if (bus.req1_valid)                          grant1 = 1'b1;
        grant_up  = grant1 ? bus.req1_up  : bus.req0_up;
        grant_len = grant1 ? bus.req1_len : bus.req0_len;
        if (grant0 || grant1) state_d = (grant_len != '0) ? RUN : DONE;
      end
      RUN: begin
        if (!bus.hold) begin
          step = 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes are suppressed during the reset cycle itself
    if (rst) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      step   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      up_q    <= 1'b0;
      rem_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        up_q    <= grant_up;
        rem_q   <= grant_len;
        owner_q <= grant1;
        ptr_q   <= grant0;
      end
      if (step) begin
        count_q <= up_q ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
        rem_q   <= rem_q - LEN_W'(1);
      end
    end
  end

  assign bus.o_ready0 = grant0;
  assign bus.o_ready1 = grant1;
  assign bus.o_step   = step;
  assign bus.o_up     = up_q;
  assign bus.o_count  = count_q;
  assign bus.o_busy   = !rst && (state_q != IDLE);
  assign bus.o_done0  = !rst && (state_q == DONE) && !owner_q;
  assign bus.o_done1  = !rst && (state_q == DONE) &&  owner_q;

endmodule

// File: tb/tb_counter_step_scheduler.sv
// Bench for counter_step_scheduler: directed vector table, hold and reset
// corner sequences, then randomized traffic against a transaction-level model.
module tb_counter_step_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_step_scheduler_if #(.LEN_W(4), .CNT_W(2)) bus ();

  counter_step_scheduler #(.LEN_W(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {ready0, ready1, step, up, count[1:0], busy, done0, done1}
  logic [8:0] outs;
  assign outs = {bus.o_ready0, bus.o_ready1, bus.o_step, bus.o_up, bus.o_count,
                 bus.o_busy, bus.o_done0, bus.o_done1};

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic       r;
    logic       v0, u0;
    logic [3:0] l0;
    logic       v1, u1;
    logic [3:0] l1;
    logic       h;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic r, input logic v0, input logic u0, input int l0,
                              input logic v1, input logic u1, input int l1, input logic h,
                              input logic [8:0] exp);
    vec_t v;
    v.r = r; v.v0 = v0; v.u0 = u0; v.l0 = 4'(l0);
    v.v1 = v1; v.u1 = u1; v.l1 = 4'(l1); v.h = h; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic v0, input logic u0, input logic [3:0] l0,
                        input logic v1, input logic u1, input logic [3:0] l1, input logic h);
    rst = r;
    bus.req0_valid = v0; bus.req0_up = u0; bus.req0_len = l0;
    bus.req1_valid = v1; bus.req1_up = u1; bus.req1_len = l1;
    bus.hold = h;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: an active run is 'left' steps followed by one done cycle
  bit m_act;
  int m_left, m_owner, m_ptr, m_count;
  bit m_up;

  task automatic model_reset();
    m_act = 0; m_left = 0; m_owner = 0; m_ptr = 0; m_count = 0; m_up = 0;
  endtask

  initial begin
    int steps, done_at;
    logic e_r0, e_r1, e_st, e_busy, e_d0, e_d1;
    logic [1:0] e_cnt;

    tbl[0]  = mk(1, 0,0,0, 0,0,0, 0, 9'b0_0_0_0_00_0_0_0);
    tbl[1]  = mk(0, 1,1,3, 0,0,0, 0, 9'b1_0_0_0_00_0_0_0);
    tbl[2]  = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_1_1_00_1_0_0);
    tbl[3]  = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_1_1_01_1_0_0);
    tbl[4]  = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_1_1_10_1_0_0);
    tbl[5]  = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_0_1_11_1_1_0);
    tbl[6]  = mk(0, 0,0,0, 1,1,1, 0, 9'b0_1_0_1_11_0_0_0);
    tbl[7]  = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_1_1_11_1_0_0);
    tbl[8]  = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_0_1_00_1_0_1);
    tbl[9]  = mk(0, 0,0,0, 1,0,2, 0, 9'b0_1_0_1_00_0_0_0);
    tbl[10] = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_1_0_00_1_0_0);
    tbl[11] = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_1_0_11_1_0_0);
    tbl[12] = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_0_0_10_1_0_1);
    tbl[13] = mk(0, 1,1,0, 0,0,0, 0, 9'b1_0_0_0_10_0_0_0);
    tbl[14] = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_0_1_10_1_1_0);
    tbl[15] = mk(0, 1,0,1, 1,1,1, 0, 9'b0_1_0_1_10_0_0_0);
    tbl[16] = mk(0, 1,0,1, 0,0,0, 0, 9'b0_0_1_1_10_1_0_0);
    tbl[17] = mk(0, 1,0,1, 0,0,0, 0, 9'b0_0_0_1_11_1_0_1);
    tbl[18] = mk(0, 1,0,1, 1,1,2, 0, 9'b1_0_0_1_11_0_0_0);
    tbl[19] = mk(0, 0,0,0, 1,1,2, 0, 9'b0_0_1_0_11_1_0_0);
    tbl[20] = mk(0, 0,0,0, 1,1,2, 0, 9'b0_0_0_0_10_1_1_0);
    tbl[21] = mk(0, 0,0,0, 1,1,2, 0, 9'b0_1_0_0_10_0_0_0);
    tbl[22] = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_1_1_10_1_0_0);
    tbl[23] = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_1_1_11_1_0_0);
    tbl[24] = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_0_1_00_1_0_1);
    tbl[25] = mk(0, 0,0,0, 0,0,0, 0, 9'b0_0_0_1_00_0_0_0);

    set_in(1, 0,0,0, 0,0,0, 0);
    adv(); adv();

    for (int i = 0; i < 26; i++) begin
      set_in(tbl[i].r, tbl[i].v0, tbl[i].u0, tbl[i].l0,
             tbl[i].v1, tbl[i].u1, tbl[i].l1, tbl[i].h);
      #3;
      check($sformatf("vec%0d", i), int'(outs), int'(tbl[i].exp));
      adv();
    end

    // Hold for two cycles in the middle of a 4-step up run starting at count 0
    set_in(0, 1,1,4, 0,0,0, 0);
    #3;
    check("hold_accept", int'(bus.o_ready0), 1);
    adv();
    set_in(0, 0,0,0, 0,0,0, 0);
    steps = 0;
    done_at = -1;
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      bus.hold = (c == 2 || c == 3);
      #3;
      if (bus.o_step) steps++;
      if (bus.o_done0) done_at = c;
      if (c == 3) check("hold_frozen_count", int'(bus.o_count), 1);
      adv();
    end
    bus.hold = 1'b0;
    check("hold_steps", steps, 4);
    check("hold_done_delay", done_at, 7);
    #3;
    check("hold_final_count", int'(bus.o_count), 0);
    adv();

    // Reset after 2 of 5 down steps from requester 0
    set_in(0, 1,0,5, 0,0,0, 0);
    #3;
    check("rst_seq_accept", int'(bus.o_ready0), 1);
    adv();
    set_in(0, 0,0,0, 0,0,0, 0);
    #3; check("rst_seq_step1", int'(bus.o_step), 1); adv();
    #3; check("rst_seq_step2", int'(bus.o_step), 1); adv();
    rst = 1'b1;
    #3;
    check("rst_cycle_strobes", int'({outs[8:6], outs[2:0]}), 0);
    adv();
    set_in(0, 1,1,1, 1,1,1, 0);
    #3;
    check("rst_after_busy", int'(bus.o_busy), 0);
    check("rst_after_count", int'(bus.o_count), 0);
    check("rst_after_up", int'(bus.o_up), 0);
    check("rst_after_no_done", int'({bus.o_done0, bus.o_done1}), 0);
    check("rst_after_ptr", int'({bus.o_ready0, bus.o_ready1}), 2);
    adv();

    // Randomized traffic against the reference model
    set_in(1, 0,0,0, 0,0,0, 0);
    adv(); adv();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.hold = ($urandom_range(0, 4) == 0);
      if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_up    = 1'($urandom);
        bus.req0_len   = 4'($urandom_range(0, 6));
      end
      if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_up    = 1'($urandom);
        bus.req1_len   = 4'($urandom_range(0, 6));
      end
      #3;
      e_r0 = 0; e_r1 = 0; e_st = 0; e_busy = 0; e_d0 = 0; e_d1 = 0;
      if (!rst) begin
        if (!m_act) begin
          if (bus.req0_valid && (!bus.req1_valid || m_ptr == 0)) e_r0 = 1;
          else if (bus.req1_valid) e_r1 = 1;
        end else begin
          e_busy = 1;
          if (m_left > 0) e_st = !bus.hold;
          else if (m_owner == 0) e_d0 = 1;
          else e_d1 = 1;
        end
      end
      e_cnt = 2'(m_count);
      check("random", int'(outs), int'({e_r0, e_r1, e_st, m_up, e_cnt, e_busy, e_d0, e_d1}));
      if (rst) begin
        model_reset();
      end else if (e_r0 || e_r1) begin
        m_act   = 1;
        m_owner = e_r1 ? 1 : 0;
        m_left  = e_r1 ? int'(bus.req1_len) : int'(bus.req0_len);
        m_up    = e_r1 ? bus.req1_up : bus.req0_up;
        m_ptr   = 1 - m_owner;
      end else if (m_act && m_left > 0) begin
        if (!bus.hold) begin
          m_count = (m_count + (m_up ? 1 : 3)) % 4;
          m_left--;
        end
      end else if (m_act) begin
        m_act = 0;
      end
      adv();
      if (e_r0) bus.req0_valid = 1'b0;
      if (e_r1) bus.req1_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
